mem_wr_sched: RTL and testbench

- Write-port scheduler for the 512x32-write / 2048x8-read dual-clock graphics buffer memory.
- Shares the single 32-bit write port between:
  - a word requester (A, SDRAM/ROM loader), which writes 32-bit words;
  - a byte requester (B, CPU), whose bytes are packed into 32-bit words before commit.
- Also sequences a full-memory clear to 0xFF, matching the memory's power-up contents.
- Sits entirely in the write clock domain and drives wren/wraddress/data directly.

---
 rtl/mem_wr_sched_pkg.sv | 13 +
 rtl/mem_wr_pack.sv | 97 +++++++++
 rtl/mem_wr_sched.sv | 165 ++++++++++++++++
 tb/tb_mem_wr_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wr_sched_pkg.sv
// Shared types and constants for the graphics-buffer write-port scheduler.
package mem_wr_sched_pkg;

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_e;

   localparam int unsigned WORDS        = 512;
   localparam int unsigned LANES        = 4;
   localparam logic [7:0]  FILL_VAL_DEF = 8'hFF;

endpackage

// File: rtl/mem_wr_pack.sv
// Byte pack buffer: gathers CPU bytes into one word and raises a pending commit
// when lane 3 is written or a byte targets a different word.
module mem_wr_pack
   import mem_wr_sched_pkg::*;
#(
   parameter logic [7:0]  FILL_VAL = FILL_VAL_DEF,
   parameter int unsigned AW       = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 en_i,
   input  logic                 commit_i,
   input  logic                 b_req_i,
   input  logic [AW+1:0]        b_addr_i,
   input  logic [7:0]           b_data_i,
   output logic                 b_ack_o,
   output logic                 pend_o,
   output logic [AW-1:0]        waddr_o,
   output logic [LANES*8-1:0]   wdata_o
);

   logic [AW-1:0]       addr_q, addr_d;
   logic [LANES*8-1:0]  lane_q, lane_d;
   logic [LANES-1:0]    vld_q, vld_d;
   logic                pend_q, pend_d;
   logic                ack_q, ack_d;

   logic [AW-1:0]       req_word;
   logic [1:0]          req_lane;
   logic                hit;
   logic                open;

   assign req_word = b_addr_i[AW+1:2];
   assign req_lane = b_addr_i[1:0];
   assign hit      = (vld_q == '0) || (req_word == addr_q);
   // A held request is not re-accepted in its own ack cycle.
   assign open     = b_req_i && en_i && !ack_q && !pend_q;

   always_comb begin
      addr_d = addr_q;
      lane_d = lane_q;
      vld_d  = vld_q;
      pend_d = pend_q;
      ack_d  = 1'b0;
      if (flush_i) begin
         vld_d  = '0;
         pend_d = 1'b0;
      end else begin
         if (commit_i) begin
            vld_d  = '0;
            pend_d = 1'b0;
         end
         if (open && hit) begin
            addr_d                    = req_word;
            lane_d[8*req_lane +: 8]   = b_data_i;
            vld_d[req_lane]           = 1'b1;
            ack_d                     = 1'b1;
            if (req_lane == 2'd3) begin
               pend_d = 1'b1;
            end
         end else if (open && !hit) begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         lane_q <= '0;
         vld_q  <= '0;
         pend_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         lane_q <= lane_d;
         vld_q  <= vld_d;
         pend_q <= pend_d;
         ack_q  <= ack_d;
      end
   end

   always_comb begin
      wdata_o = {LANES{FILL_VAL}};
      for (int unsigned i = 0; i < LANES; i++) begin
         if (vld_q[i]) begin
            wdata_o[8*i +: 8] = lane_q[8*i +: 8];
         end
      end
   end

   assign b_ack_o = ack_q;
   assign pend_o  = pend_q;
   assign waddr_o = addr_q;

endmodule

// File: rtl/mem_wr_sched.sv
// Write-port scheduler: round-robin between word writer A and packed byte commits,
// plus full-memory clear. Optional stall counter under MEM_WR_SCHED_STATS_EN.
module mem_wr_sched
   import mem_wr_sched_pkg::*;
#(
   parameter logic [7:0]  FILL_VAL   = FILL_VAL_DEF,
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic                    clr_done,
   input  logic                    a_req,
   input  logic [DEPTH_LOG2-1:0]   a_addr,
   input  logic [31:0]             a_data,
   output logic                    a_ack,
   input  logic                    b_req,
   input  logic [DEPTH_LOG2+1:0]   b_addr,
   input  logic [7:0]              b_data,
   output logic                    b_ack,
   output logic                    wren,
   output logic [DEPTH_LOG2-1:0]   wraddress,
`ifdef MEM_WR_SCHED_STATS_EN
   output logic [31:0]             data,
   output logic [15:0]             stall_cnt
`else
   output logic [31:0]             data
`endif
);

   state_e                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
   logic                    wren_q, wren_d;
   logic [DEPTH_LOG2-1:0]   waddr_q, waddr_d;
   logic [31:0]             data_q, data_d;
   logic                    a_ack_q, a_ack_d;
   logic                    done_q, done_d;
   logic                    last_b_q, last_b_d;

   logic                    a_elig, b_elig, gnt_a, gnt_b;
   logic                    flush, b_en;
   logic [DEPTH_LOG2-1:0]   pk_addr;
   logic [31:0]             pk_data;

   assign a_elig = a_req && !a_ack_q;
   assign flush  = (state_q == S_IDLE) && clr_req;
   assign b_en   = (state_q == S_IDLE) && !clr_req;

   mem_wr_pack #(
      .FILL_VAL (FILL_VAL),
      .AW       (DEPTH_LOG2)
   ) u_pack (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (flush),
      .en_i     (b_en),
      .commit_i (gnt_b),
      .b_req_i  (b_req),
      .b_addr_i (b_addr),
      .b_data_i (b_data),
      .b_ack_o  (b_ack),
      .pend_o   (b_elig),
      .waddr_o  (pk_addr),
      .wdata_o  (pk_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wren_d   = 1'b0;
      waddr_d  = waddr_q;
      data_d   = data_q;
      a_ack_d  = 1'b0;
      done_d   = 1'b0;
      last_b_d = last_b_q;
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else begin
               // last_b_q set means B won last, so A has priority on contention.
               gnt_a = a_elig && (!b_elig || last_b_q);
               gnt_b = b_elig && !gnt_a;
               if (gnt_a) begin
                  wren_d   = 1'b1;
                  waddr_d  = a_addr;
                  data_d   = a_data;
                  a_ack_d  = 1'b1;
                  last_b_d = 1'b0;
               end else if (gnt_b) begin
                  wren_d   = 1'b1;
                  waddr_d  = pk_addr;
                  data_d   = pk_data;
                  last_b_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            wren_d  = 1'b1;
            waddr_d = cnt_q;
            data_d  = {LANES{FILL_VAL}};
            if (cnt_q == '1) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wren_q   <= 1'b0;
         waddr_q  <= '0;
         data_q   <= '0;
         a_ack_q  <= 1'b0;
         done_q   <= 1'b0;
         last_b_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wren_q   <= wren_d;
         waddr_q  <= waddr_d;
         data_q   <= data_d;
         a_ack_q  <= a_ack_d;
         done_q   <= done_d;
         last_b_q <= last_b_d;
      end
   end

`ifdef MEM_WR_SCHED_STATS_EN
   logic [15:0] stall_q;
   logic        stalled;

   assign stalled = (a_elig && !gnt_a) || (b_elig && !gnt_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (clr_req) begin
         stall_q <= '0;
      end else if (stalled && (stall_q != '1)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign clr_busy  = (state_q == S_CLEAR);
   assign clr_done  = done_q;
   assign a_ack     = a_ack_q;
   assign wren      = wren_q;
   assign wraddress = waddr_q;
   assign data      = data_q;

endmodule

// File: tb/tb_mem_wr_sched.sv
// Bench for mem_wr_sched: directed scenarios then randomized A/B traffic against a stream model.
module tb_mem_wr_sched;

   logic        clk;
   logic        rst_n;
   logic        clr_req;
   logic        clr_busy;
   logic        clr_done;
   logic        a_req;
   logic [8:0]  a_addr;
   logic [31:0] a_data;
   logic        a_ack;
   logic        b_req;
   logic [10:0] b_addr;
   logic [7:0]  b_data;
   logic        b_ack;
   logic        wren;
   logic [8:0]  wraddress;
   logic [31:0] data;
`ifdef MEM_WR_SCHED_STATS_EN
   logic [15:0] stall_cnt;
`endif

   mem_wr_sched #(
      .FILL_VAL   (8'hFF),
      .DEPTH_LOG2 (9)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .a_req     (a_req),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .a_ack     (a_ack),
      .b_req     (b_req),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .b_ack     (b_ack),
      .wren      (wren),
      .wraddress (wraddress),
`ifdef MEM_WR_SCHED_STATS_EN
      .data      (data),
      .stall_cnt (stall_cnt)
`else
      .data      (data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [8:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         qa[$];
   wr_t         qb[$];
   int          wr_count = 0;
   wr_t         last_wr;
   logic        rand_mon = 1'b0;
   logic        prev_ack = 1'b0;

   always @(negedge clk) begin
      if (wren) begin
         wr_count++;
         last_wr = '{a: wraddress, d: data};
      end
      if (rand_mon) begin
         check("a_ack_gap", {63'b0, a_ack & prev_ack}, 64'd0);
         prev_ack = a_ack;
         if (wren && a_ack) begin
            if (qa.size() == 0) check("a_unexpected", {23'b0, wraddress, data}, 64'd0);
            else check("rand_a", {23'b0, wraddress, data}, {23'b0, qa.pop_front()});
         end else if (wren) begin
            if (qb.size() == 0) check("b_unexpected", {23'b0, wraddress, data}, 64'd0);
            else check("rand_b", {23'b0, wraddress, data}, {23'b0, qb.pop_front()});
         end else if (a_ack) begin
            check("ack_no_wren", 64'd1, 64'd0);
         end
      end
   end

   task automatic a_send(input logic [8:0] ad, input logic [31:0] dt);
      logic got;
      got    = 1'b0;
      a_req  = 1'b1;
      a_addr = ad;
      a_data = dt;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (a_ack) begin
            got = 1'b1;
            break;
         end
      end
      a_req = 1'b0;
      check("a_ack_seen", {63'b0, got}, 64'd1);
   endtask

   task automatic b_send(input logic [10:0] ad, input logic [7:0] dt);
      logic got;
      got    = 1'b0;
      b_req  = 1'b1;
      b_addr = ad;
      b_data = dt;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (b_ack) begin
            got = 1'b1;
            break;
         end
      end
      b_req = 1'b0;
      check("b_ack_seen", {63'b0, got}, 64'd1);
   endtask

   task automatic wait_wren(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (wren) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, {63'b0, got}, 64'd1);
   endtask

   function automatic logic [31:0] fill_word(input logic [31:0] l, input logic [3:0] v);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = v[k] ? l[8*k +: 8] : 8'hFF;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int          w0, busy, nwr, addr_err, ack_err;
      logic        seen;
      int          kind, exp_kind;
      logic [10:0] bav[$];
      logic [7:0]  bdv[$];
      wr_t         alist[$];
      logic [8:0]  mw, w;
      logic [31:0] ml;
      logic [3:0]  mv;
      logic [1:0]  ln;

      rst_n = 1'b0; clr_req = 1'b0; a_req = 1'b0; a_addr = '0; a_data = '0;
      b_req = 1'b0; b_addr = '0; b_data = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_wren", {63'b0, wren}, 64'd0);
      check("rst_wraddr", {55'b0, wraddress}, 64'd0);
      check("rst_data", {32'b0, data}, 64'd0);
      check("rst_acks", {62'b0, a_ack, b_ack}, 64'd0);
      check("rst_clr", {62'b0, clr_busy, clr_done}, 64'd0);

      // Single A write: one-cycle latency, exactly one write
      w0 = wr_count;
      a_req = 1'b1; a_addr = 9'h010; a_data = 32'h11223344;
      tick();
      check("a1_ack_wren", {62'b0, a_ack, wren}, 64'd3);
      check("a1_word", {23'b0, wraddress, data}, {23'b0, 9'h010, 32'h11223344});
      a_req = 1'b0;
      tick();
      check("a1_once", {63'b0, wren}, 64'd0);
      check("a1_count", 64'(wr_count - w0), 64'd1);

      // Four bytes into one word
      w0 = wr_count;
      b_send(11'h040, 8'hAA);
      b_send(11'h041, 8'hBB);
      b_send(11'h042, 8'hCC);
      b_send(11'h043, 8'hDD);
      wait_wren("b4_wren");
      check("b4_word", {23'b0, wraddress, data}, {23'b0, 9'h010, 32'hDDCCBBAA});
      tick();
      check("b4_count", 64'(wr_count - w0), 64'd1);

      // Address change forces a partial commit with fill lanes
      w0 = wr_count;
      b_send(11'h041, 8'h55);
      b_send(11'h080, 8'h66);
      check("split_count", 64'(wr_count - w0), 64'd1);
      check("split_word", {23'b0, last_wr}, {23'b0, 9'h010, 32'hFFFF55FF});
      b_send(11'h083, 8'h77);
      wait_wren("split2_wren");
      check("split2_word", {23'b0, wraddress, data}, {23'b0, 9'h020, 32'h77FFFF66});

      // Held A with a B commit pending: A,B,A,-,A,-,...
      b_send(11'h0C0, 8'h11);
      b_send(11'h0C1, 8'h22);
      b_send(11'h0C2, 8'h33);
      tick();
      a_req = 1'b1; a_addr = 9'h1AB; a_data = 32'hCAFEF00D;
      b_req = 1'b1; b_addr = 11'h0C3; b_data = 8'h44;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) check("alt_b_ack", {63'b0, b_ack}, 64'd1);
         if (b_ack) b_req = 1'b0;
         kind     = wren ? (a_ack ? 1 : 2) : (a_ack ? 3 : 0);
         exp_kind = (i == 1) ? 2 : ((i % 2 == 0) ? 1 : 0);
         check($sformatf("alt_kind%0d", i), 64'(kind), 64'(exp_kind));
         if (i == 1) check("alt_b_word", {23'b0, wraddress, data}, {23'b0, 9'h030, 32'h44332211});
      end
      a_req = 1'b0; b_req = 1'b0;
      tick(); tick();

      // Clear with A held: clear wins, then A served
      clr_req = 1'b1; a_req = 1'b1; a_addr = 9'h055; a_data = 32'h12345678;
      tick();
      clr_req = 1'b0;
      check("clr_entry_noack", {62'b0, a_ack, wren}, 64'd0);
      busy = 0; nwr = 0; addr_err = 0; ack_err = 0; seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if (clr_busy) busy++;
         if (a_ack) ack_err++;
         if (wren) begin
            if (wraddress !== 9'(nwr) || data !== 32'hFFFFFFFF) addr_err++;
            nwr++;
         end
         if (clr_done) begin
            seen = 1'b1;
            break;
         end
         clr_req = (nwr == 100);
         tick();
         clr_req = 1'b0;
      end
      check("clr_done_seen", {63'b0, seen}, 64'd1);
      check("clr_busy_cycles", 64'(busy), 64'd512);
      check("clr_writes", 64'(nwr), 64'd512);
      check("clr_addr_data", 64'(addr_err), 64'd0);
      check("clr_no_ack", 64'(ack_err), 64'd0);
      tick();
      check("clr_done_pulse", {63'b0, clr_done}, 64'd0);
      check("post_clr_a", {22'b0, a_ack, wren, wraddress, data}, {22'b0, 2'b11, 9'h055, 32'h12345678});
      a_req = 1'b0;
      tick();

      // Reset in the middle of a clear
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (wren && wraddress == 9'd200) begin
            seen = 1'b1;
            break;
         end
      end
      check("mid_clr_200", {63'b0, seen}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", {61'b0, wren, clr_busy, clr_done}, 64'd0);
      check("mid_rst_addr", {55'b0, wraddress}, 64'd0);
      rst_n = 1'b1;
      tick();
      check("mid_rst_idle", {62'b0, clr_busy, wren}, 64'd0);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      check("restart_addr0", {53'b0, wren, wraddress, clr_busy}, {53'b0, 1'b1, 9'd0, 1'b1});
      seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         tick();
         if (clr_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("restart_done", {63'b0, seen}, 64'd1);
      tick();

      // Randomized traffic: expected streams come from the packing rules
      mw = 9'h040;
      for (int i = 0; i < 70; i++) begin
         w  = ($urandom_range(0, 9) < 7) ? mw : 9'(32'h40 + $urandom_range(0, 3));
         ln = 2'($urandom_range(0, 3));
         if (i == 69) ln = 2'd3;
         bav.push_back({w, ln});
         bdv.push_back(8'($urandom));
         mw = w;
      end
      for (int i = 0; i < 40; i++) alist.push_back('{a: 9'($urandom), d: $urandom});
      mv = '0; ml = '0; mw = '0;
      foreach (bav[i]) begin
         w  = bav[i][10:2];
         ln = bav[i][1:0];
         if (mv != 0 && w != mw) begin
            qb.push_back('{a: mw, d: fill_word(ml, mv)});
            mv = '0;
         end
         mw = w;
         ml[8*ln +: 8] = bdv[i];
         mv[ln] = 1'b1;
         if (ln == 2'd3) begin
            qb.push_back('{a: mw, d: fill_word(ml, mv)});
            mv = '0;
         end
      end
      foreach (alist[i]) qa.push_back(alist[i]);
      rand_mon = 1'b1;
      fork
         begin
            foreach (alist[i]) begin
               repeat ($urandom_range(0, 3)) tick();
               a_send(alist[i].a, alist[i].d);
            end
         end
         begin
            foreach (bav[i]) begin
               repeat ($urandom_range(0, 2)) tick();
               b_send(bav[i], bdv[i]);
            end
         end
      join
      repeat (10) tick();
      rand_mon = 1'b0;
      check("rand_a_left", 64'(qa.size()), 64'd0);
      check("rand_b_left", 64'(qb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
